// File: rtl/dpc_sort_pkg.sv
// Shared types and constants for the DPC rank sorter.
package dpc_sort_pkg;

  localparam int unsigned SORT_LAT = 4;

  typedef enum logic {
    ASCEND  = 1'b0,
    DESCEND = 1'b1
  } sort_dir_e;

  // Index/rank width for an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpc_rank_row.sv
// One row of the pairwise compare matrix: counts the samples that precede
// sample ROW, giving its rank in the sorted vector.
module dpc_rank_row
  import dpc_sort_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DATA_NUM   = 9,
  parameter  int unsigned ROW        = 0,
  localparam int unsigned IDX_W      = idx_width(DATA_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_descend,
  input  logic [DATA_WIDTH-1:0] i_data [DATA_NUM],
  output logic [IDX_W-1:0]      o_rank
);

  logic [DATA_NUM-1:0] w_before;
  logic [DATA_NUM-1:0] r_before;
  logic [IDX_W-1:0]    w_cnt;
  logic [IDX_W-1:0]    r_rank;

  // Ties resolve by original index so equal samples stay in input order.
  always_comb begin
    w_before = '0;
    for (int unsigned o = 0; o < DATA_NUM; o++) begin
      if (o != ROW) begin
        if (i_data[o] == i_data[ROW]) begin
          w_before[o] = (o < ROW);
        end else if (i_descend) begin
          w_before[o] = (i_data[o] > i_data[ROW]);
        end else begin
          w_before[o] = (i_data[o] < i_data[ROW]);
        end
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int unsigned o = 0; o < DATA_NUM; o++) begin
      w_cnt = w_cnt + IDX_W'(r_before[o]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_before <= '0;
      r_rank   <= '0;
    end else if (i_en) begin
      r_before <= w_before;
      r_rank   <= w_cnt;
    end
  end

  assign o_rank = r_rank;

endmodule

// File: rtl/dpc_rank_sorter.sv
// Streaming rank sorter: compare matrix, rank scatter and registered output
// with source indices, median, min and max. Whole pipeline stalls together.
module dpc_rank_sorter
  import dpc_sort_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DATA_NUM   = 9,
  localparam int unsigned IDX_W      = idx_width(DATA_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_descend,
  input  logic [DATA_WIDTH-1:0] in_data     [DATA_NUM],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data    [DATA_NUM],
  output logic [IDX_W-1:0]      out_src_idx [DATA_NUM],
  output logic [DATA_WIDTH-1:0] out_median,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [DATA_WIDTH-1:0] out_max
);

  localparam int unsigned MED = (DATA_NUM - 1) / 2;

  logic                  w_en;
  logic [SORT_LAT-1:0]   r_vld;
  sort_dir_e             r_s0_dir;
  sort_dir_e             r_s1_dir;
  sort_dir_e             r_s2_dir;
  sort_dir_e             r_s3_dir;
  logic [DATA_WIDTH-1:0] r_s0_data [DATA_NUM];
  logic [DATA_WIDTH-1:0] r_s1_data [DATA_NUM];
  logic [DATA_WIDTH-1:0] r_s2_data [DATA_NUM];
  logic [IDX_W-1:0]      w_rank    [DATA_NUM];
  logic [DATA_WIDTH-1:0] w_sort    [DATA_NUM];
  logic [IDX_W-1:0]      w_idx     [DATA_NUM];
  logic [DATA_WIDTH-1:0] r_sort    [DATA_NUM];
  logic [IDX_W-1:0]      r_idx     [DATA_NUM];

  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;

  for (genvar g = 0; g < DATA_NUM; g++) begin : g_row
    dpc_rank_row #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_NUM   (DATA_NUM),
      .ROW        (g)
    ) u_row (
      .clk       (clk),
      .reset     (reset),
      .i_en      (w_en),
      .i_descend (r_s0_dir == DESCEND),
      .i_data    (r_s0_data),
      .o_rank    (w_rank[g])
    );
  end

  // Ranks are a permutation, so exactly one source matches each slot.
  always_comb begin
    for (int unsigned j = 0; j < DATA_NUM; j++) begin
      w_sort[j] = '0;
      w_idx[j]  = '0;
      for (int unsigned i = 0; i < DATA_NUM; i++) begin
        if (w_rank[i] == IDX_W'(j)) begin
          w_sort[j] = r_s2_data[i];
          w_idx[j]  = IDX_W'(i);
        end
      end
    end
  end

  // Capture, delay and scatter stages; bubbles still load their data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld    <= '0;
      r_s0_dir <= ASCEND;
      r_s1_dir <= ASCEND;
      r_s2_dir <= ASCEND;
      r_s3_dir <= ASCEND;
      for (int unsigned i = 0; i < DATA_NUM; i++) begin
        r_s0_data[i] <= '0;
        r_s1_data[i] <= '0;
        r_s2_data[i] <= '0;
        r_sort[i]    <= '0;
        r_idx[i]     <= '0;
      end
    end else if (w_en) begin
      r_vld     <= {r_vld[SORT_LAT-2:0], in_valid};
      r_s0_dir  <= sort_dir_e'(in_descend);
      r_s1_dir  <= r_s0_dir;
      r_s2_dir  <= r_s1_dir;
      r_s3_dir  <= r_s2_dir;
      r_s0_data <= in_data;
      r_s1_data <= r_s0_data;
      r_s2_data <= r_s1_data;
      r_sort    <= w_sort;
      r_idx     <= w_idx;
    end
  end

  // Output stage; min/max swap ends when the vector is descending.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_median <= '0;
      out_min    <= '0;
      out_max    <= '0;
      for (int unsigned i = 0; i < DATA_NUM; i++) begin
        out_data[i]    <= '0;
        out_src_idx[i] <= '0;
      end
    end else if (w_en) begin
      out_valid   <= r_vld[SORT_LAT-1];
      out_data    <= r_sort;
      out_src_idx <= r_idx;
      out_median  <= r_sort[MED];
      out_min     <= (r_s3_dir == DESCEND) ? r_sort[DATA_NUM-1] : r_sort[0];
      out_max     <= (r_s3_dir == DESCEND) ? r_sort[0] : r_sort[DATA_NUM-1];
    end
  end

endmodule

// File: tb/tb_dpc_rank_sorter.sv
// Scoreboard bench for dpc_rank_sorter: 9x16 instance under random traffic
// and stalls, plus a 16x12 instance for unsigned extreme-value ordering.
module tb_dpc_rank_sorter;

  localparam int N    = 9;
  localparam int W    = 16;
  localparam int IW   = 4;
  localparam int N16  = 16;
  localparam int W16  = 12;
  localparam int IW16 = 4;

  localparam int A1      [9]  = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
  localparam int A1_AIDX [9]  = '{1, 3, 5, 7, 8, 6, 4, 2, 0};
  localparam int A1_DIDX [9]  = '{0, 2, 4, 6, 8, 7, 5, 3, 1};
  localparam int MIX     [9]  = '{3, 3, 1, 3, 2, 3, 1, 3, 3};
  localparam int A16     [16] = '{'hFFF, 0, 'hFFF, 'h800, 0, 'h7FF, 'hFFF, 1,
                                  0, 'hFFE, 'hFFF, 0, 'h123, 'hFFF, 0, 'hABC};
  localparam int ASC16_D [16] = '{0, 0, 0, 0, 0, 1, 'h123, 'h7FF, 'h800, 'hABC,
                                  'hFFE, 'hFFF, 'hFFF, 'hFFF, 'hFFF, 'hFFF};
  localparam int ASC16_I [16] = '{1, 4, 8, 11, 14, 7, 12, 5, 3, 15, 9, 0, 2, 6, 10, 13};
  localparam int DSC16_D [16] = '{'hFFF, 'hFFF, 'hFFF, 'hFFF, 'hFFF, 'hFFE, 'hABC,
                                  'h800, 'h7FF, 'h123, 1, 0, 0, 0, 0, 0};
  localparam int DSC16_I [16] = '{0, 2, 6, 10, 13, 9, 15, 3, 5, 12, 7, 1, 4, 8, 11, 14};

  typedef struct packed {
    logic [N-1:0][W-1:0]  data;
    logic [N-1:0][IW-1:0] idx;
    logic [W-1:0]         med;
    logic [W-1:0]         mn;
    logic [W-1:0]         mx;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_descend = 1'b0;
  logic [W-1:0]    in_data [N];
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data [N];
  logic [IW-1:0]   out_src_idx [N];
  logic [W-1:0]    out_median, out_min, out_max;

  logic            in_valid16 = 1'b0;
  logic            in_ready16;
  logic            in_descend16 = 1'b0;
  logic [W16-1:0]  in_data16 [N16];
  logic            out_valid16;
  logic            out_ready16 = 1'b1;
  logic [W16-1:0]  out_data16 [N16];
  logic [IW16-1:0] out_src_idx16 [N16];
  logic [W16-1:0]  out_median16, out_min16, out_max16;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_out   = 0;
  logic mon_en  = 1'b0;
  logic stall_prev = 1'b0;
  logic [N-1:0][W-1:0]  pd;
  logic [N-1:0][IW-1:0] pi;
  logic [W-1:0]         pm;

  always #5 clk = ~clk;

  dpc_rank_sorter #(.DATA_WIDTH(W), .DATA_NUM(N)) u_dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready), .in_descend (in_descend),
    .in_data (in_data),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_src_idx (out_src_idx),
    .out_median (out_median), .out_min (out_min), .out_max (out_max)
  );

  dpc_rank_sorter #(.DATA_WIDTH(W16), .DATA_NUM(N16)) u_dut16 (
    .clk (clk), .reset (reset),
    .in_valid (in_valid16), .in_ready (in_ready16), .in_descend (in_descend16),
    .in_data (in_data16),
    .out_valid (out_valid16), .out_ready (out_ready16),
    .out_data (out_data16), .out_src_idx (out_src_idx16),
    .out_median (out_median16), .out_min (out_min16), .out_max (out_max16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: stable insertion sort plus a direct min/max scan of the input.
  function automatic exp_t model(input logic [N-1:0][W-1:0] d, input logic dsc);
    exp_t e;
    logic [W-1:0]  kd;
    logic [IW-1:0] ki;
    int j;
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.data[i] = d[i];
      e.idx[i]  = IW'(i);
    end
    for (int i = 1; i < N; i++) begin
      kd = e.data[i];
      ki = e.idx[i];
      j  = i - 1;
      while (j >= 0 && (dsc ? (e.data[j] < kd) : (e.data[j] > kd))) begin
        e.data[j+1] = e.data[j];
        e.idx[j+1]  = e.idx[j];
        j--;
      end
      e.data[j+1] = kd;
      e.idx[j+1]  = ki;
    end
    e.med = e.data[(N-1)/2];
    e.mn  = d[0];
    e.mx  = d[0];
    for (int i = 1; i < N; i++) begin
      if (d[i] < e.mn) e.mn = d[i];
      if (d[i] > e.mx) e.mx = d[i];
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic dsc, input logic [N-1:0][W-1:0] d,
                       input logic ordy, input logic rst, input exp_t e);
    @(posedge clk);
    #1;
    reset      = rst;
    in_valid   = v;
    in_descend = dsc;
    out_ready  = ordy;
    for (int i = 0; i < N; i++) in_data[i] = d[i];
    @(negedge clk);
    if (rst) sb_q.delete();
    else if (v && in_ready) begin
      sb_q.push_back(e);
      n_acc++;
    end
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, '0, ordy, 1'b0, '0);
  endtask

  // Monitor: handshake rule, stall stability and in-order scoreboard compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (reset) stall_prev = 1'b0;
        else begin
          check("in_ready_rule", in_ready, !(out_valid && !out_ready));
          if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_med", out_median, pm);
            for (int i = 0; i < N; i++) begin
              check($sformatf("stall_data%0d", i), out_data[i], pd[i]);
              check($sformatf("stall_idx%0d", i), out_src_idx[i], pi[i]);
            end
          end
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("spurious_out", out_valid, 0);
            else begin
              e = sb_q.pop_front();
              n_out++;
              for (int i = 0; i < N; i++) begin
                check($sformatf("data%0d", i), out_data[i], e.data[i]);
                check($sformatf("idx%0d", i), out_src_idx[i], e.idx[i]);
              end
              check("median", out_median, e.med);
              check("min", out_min, e.mn);
              check("max", out_max, e.mx);
            end
          end
          stall_prev = out_valid && !out_ready;
          for (int i = 0; i < N; i++) begin
            pd[i] = out_data[i];
            pi[i] = out_src_idx[i];
          end
          pm = out_median;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N-1:0][W-1:0] v;
    exp_t e;
    logic dsc, vld, ordy, got;
    int cyc, out0;

    for (int i = 0; i < N; i++) in_data[i] = '0;
    for (int i = 0; i < N16; i++) in_data16[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_median", out_median, 0);
    check("rst_min", out_min, 0);
    check("rst_max", out_max, 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_data%0d", i), out_data[i], 0);
      check($sformatf("rst_idx%0d", i), out_src_idx[i], 0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    mon_en = 1'b1;

    // Ascending directed vector with latency check
    for (int i = 0; i < N; i++) v[i] = W'(A1[i]);
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.data[i] = W'(i + 1);
      e.idx[i]  = IW'(A1_AIDX[i]);
    end
    e.med = 16'd5; e.mn = 16'd1; e.mx = 16'd9;
    drive(1'b1, 1'b0, v, 1'b1, 1'b0, e);
    for (int c = 1; c <= 5; c++) begin
      idle(1'b1);
      check($sformatf("latency_c%0d", c), out_valid, (c == 5) ? 1 : 0);
    end

    // Descending, same vector
    for (int i = 0; i < N; i++) begin
      e.data[i] = W'(9 - i);
      e.idx[i]  = IW'(A1_DIDX[i]);
    end
    drive(1'b1, 1'b1, v, 1'b1, 1'b0, e);

    // All-equal and mixed ties, both directions, back to back
    for (int i = 0; i < N; i++) begin
      v[i]      = 16'h0100;
      e.data[i] = 16'h0100;
      e.idx[i]  = IW'(i);
    end
    e.med = 16'h0100; e.mn = 16'h0100; e.mx = 16'h0100;
    drive(1'b1, 1'b0, v, 1'b1, 1'b0, e);
    drive(1'b1, 1'b1, v, 1'b1, 1'b0, e);
    for (int i = 0; i < N; i++) v[i] = W'(MIX[i]);
    drive(1'b1, 1'b0, v, 1'b1, 1'b0, model(v, 1'b0));
    drive(1'b1, 1'b1, v, 1'b1, 1'b0, model(v, 1'b1));
    repeat (8) idle(1'b1);
    check("directed_drained", 32'(sb_q.size()), 0);

    // Random traffic with stalls and direction toggling
    n_acc = 0;
    out0  = n_out;
    cyc   = 0;
    while (n_acc < 200 && cyc < 3000) begin
      for (int i = 0; i < N; i++)
        v[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      dsc  = 1'($urandom_range(0, 1));
      vld  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      drive(vld, dsc, v, ordy, 1'b0, model(v, dsc));
      cyc++;
    end
    check("rand_accepted", n_acc, 200);
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin
      idle(1'b1);
      cyc++;
    end
    check("rand_drained", 32'(sb_q.size()), 0);
    check("rand_out_count", n_out - out0, 200);

    // Reset with three vectors in flight
    for (int i = 0; i < N; i++) v[i] = W'(100 + i);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, v, 1'b1, 1'b0, model(v, 1'b0));
    drive(1'b1, 1'b0, v, 1'b1, 1'b1, '0);
    idle(1'b1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_median", out_median, 0);
    check("midrst_min", out_min, 0);
    check("midrst_max", out_max, 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("midrst_data%0d", i), out_data[i], 0);
      check($sformatf("midrst_idx%0d", i), out_src_idx[i], 0);
    end
    out0 = n_out;
    repeat (10) idle(1'b1);
    check("midrst_no_emit", n_out - out0, 0);

    // 16 x 12-bit instance, unsigned extremes, both directions
    for (int p = 0; p < 2; p++) begin
      @(posedge clk);
      #1;
      in_valid16   = 1'b1;
      in_descend16 = 1'(p);
      for (int i = 0; i < N16; i++) in_data16[i] = W16'(A16[i]);
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (out_valid16) got = 1'b1;
      end
      check($sformatf("d16_seen_p%0d", p), got, 1);
      if (got) begin
        for (int i = 0; i < N16; i++) begin
          check($sformatf("d16_p%0d_data%0d", p, i), out_data16[i],
                (p == 0) ? ASC16_D[i] : DSC16_D[i]);
          check($sformatf("d16_p%0d_idx%0d", p, i), out_src_idx16[i],
                (p == 0) ? ASC16_I[i] : DSC16_I[i]);
        end
        check($sformatf("d16_p%0d_median", p), out_median16, (p == 0) ? 'h7FF : 'h800);
        check($sformatf("d16_p%0d_min", p), out_min16, 'h000);
        check($sformatf("d16_p%0d_max", p), out_max16, 'hFFF);
      end
    end

    repeat (2) idle(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpc_rank_sorter.md
# dpc_rank_sorter

Parametrised, streaming rank sorter for the DPC path. It sorts a window of DATA_NUM unsigned samples in one pass, using a pairwise compare matrix followed by a rank scatter. Each sorted vector comes out with its source indices, median, min and max. It sits between the DPC window gatherer and the defect decision logic, with a valid/ready handshake and a run-time sort direction.

## Interface
- DATA_WIDTH, 16: sample width, unsigned
- DATA_NUM, 9: samples per vector, 2..32
- IDX_W, $clog2(DATA_NUM): index/rank width (derived localparam, not overridable)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input this cycle
- in_descend  in  1  0 = ascending, 1 = descending; sampled with the vector
- in_data  in  DATA_WIDTH x DATA_NUM  unpacked input samples
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_WIDTH x DATA_NUM  sorted samples
- out_src_idx  out  IDX_W x DATA_NUM  original index of each out_data entry
- out_median  out  DATA_WIDTH  out_data[(DATA_NUM-1)/2] (lower median when DATA_NUM is even)
- out_min / out_max  out  DATA_WIDTH  smallest / largest sample, independent of direction

## Operation
- Four-stage pipeline; all stages advance together on en = out_ready | ~out_valid.
- in_ready = en (combinational). A transfer occurs when in_valid & in_ready.
- S0 (capture): register in_data and in_descend; valid bit = in_valid.
- S1 (compare): per pair (i,o), before[i][o] = 1 when sample o precedes sample i.
  - Ascending: d[o] < d[i], or d[o] == d[i] and o < i.
  - Descending: d[o] > d[i], or d[o] == d[i] and o < i.
  - Diagonal is 0. Data and direction are delayed alongside.
- S2 (scatter): rank[i] = popcount(before[i][*]), range 0..DATA_NUM-1; ranks form a permutation by construction.
  - sort[rank[i]] <= d[i]; idx[rank[i]] <= i.
- S3 (output): register sort and idx, median = sort[(DATA_NUM-1)/2], min/max = sort[0] / sort[N-1], swapped when descending.
- Ties are stable: equal samples keep ascending original-index order in both directions.
- Comparison is unsigned, full DATA_WIDTH.
- Bubbles are not collapsed. An invalid slot travels with valid = 0, and its data registers still load.

## Timing
- Latency is 4 cycles: a vector accepted at edge k gives out_valid = 1 after edge k+4 when no stall occurs.
- Throughput is 1 vector per cycle while out_ready = 1.
- Stall: when out_valid & ~out_ready, every stage holds and in_ready = 0. All out_* are stable until accepted.
- When out_valid = 0, the pipeline advances regardless of out_ready.
- Reset values: out_valid 0, out_data/out_src_idx/out_median/out_min/out_max 0, and every stage register 0.
  - in_ready is 1 the cycle after reset deasserts.
- Reset mid-flight: all in-flight vectors are discarded; none appears after reset.
  - Reset wins over simultaneous in_valid or out_ready.
- in_descend changing between vectors takes effect per vector, with no cross-contamination.

## Structure
- Package dpc_sort_pkg: holds the idx_width() function, the sort_dir_e enum (ASCEND/DESCEND) and the stage count constant SORT_LAT = 4.
- Sub-module dpc_rank_row holds one row i of the compare matrix plus its popcount. It has a combinational compare and a registered rank. The top generates DATA_NUM instances.
- The top holds the handshake, the valid/direction pipeline, the scatter and the output stage.

## Test plan
All scenarios use DATA_NUM = 9 except scenario 6.
1. Ascending: in {9,1,8,2,7,3,6,4,5} -> out_data {1..9}, out_src_idx {1,3,5,7,8,6,4,2,0}, median 5, min 1, max 9, out_valid exactly 4 cycles after accept.
2. Descending, same vector -> out_data {9..1}, out_src_idx {0,2,4,6,8,7,5,3,1}, median 5, min 1, max 9.
3. All samples 0x0100, both directions -> out_data all 0x0100, out_src_idx {0..8} (stable ties); mixed {3,3,1,3,...} keeps equal samples in index order.
4. 200 random back-to-back vectors, random in_valid and random out_ready, direction toggling -> scoreboard checks no loss, duplication or reorder; outputs held stable during stall; in_ready low only when out_valid & ~out_ready.
5. Accept 3 vectors, then pulse reset 1 cycle with out_ready = 1 -> out_valid = 0 and all outputs 0 next cycle; none of the 3 vectors is ever emitted.
6. DATA_NUM = 16, DATA_WIDTH = 12, samples mixing 0xFFF and 0x000 -> correct unsigned order; out_min = 0x000, out_max = 0xFFF, out_median = out_data[7].
